// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl
// Sequencing controller between decode and the FPU datapath / FP register file.
// Accepts one FP operation at a time. It resolves the rounding mode (a static rm,
// or the dynamic csr_frm when rm=111), pulses the FPU start, waits for the
// result with a timeout, and writes the result back to the FP RF. It keeps sticky
// fflags and reports an illegal rounding mode or an FPU timeout through err.
//
// Handshake: an op transfers on a rising clk edge when req_valid && req_ready.
// req_ready is high only in IDLE. After the transfer, req_valid is ignored until
// the controller is back in IDLE. The first IDLE cycle after done can accept the
// next op.
//
// Ports
//   clk, n_rst            clock, asynchronous active-low reset
//   req_*                 decoded FP op from decode (valid/ready handshake)
//   dload_ext             load data for FLW
//   csr_frm               dynamic rounding mode
//   fpu_start/op/rs1/rs2/frm  FPU issue (start is a one-cycle pulse)
//   fpu_ready/result/flags    FPU completion (sampled in WAIT only)
//   f_wen/f_rd/f_wdata    FP RF write port
//   done/err              completion pulse and status (00 ok, 01 bad rm, 10 timeout)
//   fflags_acc            sticky NV,DZ,OF,UF,NX
//   fflags_wr/wdata       CSR write of fflags
//   dbg_state             current FSM state (observation only)
module fpu_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_funct7,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [4:0]  req_rd,
  input  logic [2:0]  req_rm,
  input  logic        req_is_load,
  input  logic        req_is_store,
  input  logic [31:0] dload_ext,
  input  logic [2:0]  csr_frm,
  output logic        fpu_start,
  output logic [6:0]  fpu_op,
  output logic [4:0]  fpu_rs1,
  output logic [4:0]  fpu_rs2,
  output logic [2:0]  fpu_frm,
  input  logic        fpu_ready,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_flags,
  output logic        f_wen,
  output logic [4:0]  f_rd,
  output logic [31:0] f_wdata,
  output logic        done,
  output logic [1:0]  err,
  output logic [4:0]  fflags_acc,
  input  logic        fflags_wr,
  input  logic [4:0]  fflags_wdata,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WB    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_BAD_RM  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_req_ready;
  logic        r_fpu_start;
  logic [6:0]  r_fpu_op;
  logic [4:0]  r_fpu_rs1;
  logic [4:0]  r_fpu_rs2;
  logic [2:0]  r_fpu_frm;
  logic [4:0]  r_rd;
  logic [4:0]  r_flags;
  logic        r_f_wen;
  logic [4:0]  r_f_rd;
  logic [31:0] r_f_wdata;
  logic        r_done;
  logic [1:0]  r_err;
  logic [4:0]  r_fflags_acc;

  logic [2:0]  w_rm_res;
  logic        w_rm_bad;
  logic [4:0]  w_wb_flags;

  // rm=111 selects the dynamic mode from fcsr. The encodings 101..111 are
  // reserved, so a dynamic frm of 111 is also illegal.
  assign w_rm_res   = (req_rm == 3'b111) ? csr_frm : req_rm;
  assign w_rm_bad   = (w_rm_res >= 3'b101);
  assign w_wb_flags = (r_state == S_WB) ? r_flags : 5'b0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_req_ready  <= 1'b1;
      r_fpu_start  <= 1'b0;
      r_fpu_op     <= 7'd0;
      r_fpu_rs1    <= 5'd0;
      r_fpu_rs2    <= 5'd0;
      r_fpu_frm    <= 3'd0;
      r_rd         <= 5'd0;
      r_flags      <= 5'd0;
      r_f_wen      <= 1'b0;
      r_f_rd       <= 5'd0;
      r_f_wdata    <= 32'd0;
      r_done       <= 1'b0;
      r_err        <= 2'b00;
      r_fflags_acc <= 5'd0;
    end else begin
      // The pulse outputs default low. Each transition raises the ones it needs,
      // so every pulse lasts exactly one state.
      r_fpu_start <= 1'b0;
      r_f_wen     <= 1'b0;
      r_f_rd      <= 5'd0;
      r_f_wdata   <= 32'd0;
      r_done      <= 1'b0;
      r_err       <= ERR_OK;

      // A CSR write and the WB accumulation in the same cycle both take effect.
      if (fflags_wr) begin
        r_fflags_acc <= fflags_wdata | w_wb_flags;
      end else begin
        r_fflags_acc <= r_fflags_acc | w_wb_flags;
      end

      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_req_ready <= 1'b0;
            r_fpu_op    <= req_funct7;
            r_fpu_rs1   <= req_rs1;
            r_fpu_rs2   <= req_rs2;
            r_fpu_frm   <= w_rm_res;
            r_rd        <= req_rd;
            r_flags     <= 5'd0;
            if (w_rm_bad) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= ERR_BAD_RM;
            end else if (req_is_load) begin
              // A load writes the memory data directly and contributes no flags.
              r_state   <= S_WB;
              r_f_wen   <= 1'b1;
              r_f_rd    <= req_rd;
              r_f_wdata <= dload_ext;
              r_done    <= 1'b1;
            end else if (req_is_store) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_ISSUE;
              r_fpu_start <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          r_state <= S_WAIT;
          r_cnt   <= 8'd0;
        end

        S_WAIT: begin
          if (fpu_ready) begin
            r_state   <= S_WB;
            r_flags   <= fpu_flags;
            r_f_wen   <= 1'b1;
            r_f_rd    <= r_rd;
            r_f_wdata <= fpu_result;
            r_done    <= 1'b1;
          end else if (r_cnt == TO_LAST) begin
            // Abort: no RF write and no flag update.
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= ERR_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_WB: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end

        S_DONE: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end

        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign fpu_start  = r_fpu_start;
  assign fpu_op     = r_fpu_op;
  assign fpu_rs1    = r_fpu_rs1;
  assign fpu_rs2    = r_fpu_rs2;
  assign fpu_frm    = r_fpu_frm;
  assign f_wen      = r_f_wen;
  assign f_rd       = r_f_rd;
  assign f_wdata    = r_f_wdata;
  assign done       = r_done;
  assign err        = r_err;
  assign fflags_acc = r_fflags_acc;
  assign dbg_state  = r_state;

endmodule
